// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: opcodes, R-type opexts,
// FSM state codes, PSR flag bit positions and the decode class bundle.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_CMP   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_MOVIU = 4'b0111;
  localparam logic [3:0] OP_MOVI  = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_RSHI  = 4'b1110;

  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_RSH  = 4'b1110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  typedef struct packed {
    logic is_imm;
    logic imm_signed;
    logic swap_ab;
    logic writes;
    logic sets_flags;
  } op_class_t;

  function automatic logic [15:0] imm_ext(
    input logic [7:0] imm,
    input logic       sgn
  );
    return sgn ? {{8{imm[7]}}, imm} : {8'h00, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_classify.sv
// Combinational decode of opcode/opext into operand-routing and side-effect class.
// Ports: i_opcode, i_opext in; o_cls (is_imm, imm_signed, swap_ab, writes, sets_flags) out.
module alu_op_classify
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic [3:0] i_opext,
  output op_class_t  o_cls
);

  always_comb begin
    o_cls = '0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_opext)
          EXT_ADD, EXT_ADDU, EXT_SUB: begin
            o_cls.writes     = 1'b1;
            o_cls.sets_flags = 1'b1;
          end
          EXT_AND, EXT_OR, EXT_XOR,
          EXT_MOV, EXT_RSH: begin
            o_cls.writes = 1'b1;
          end
          // opext 0000 is NOP; other opexts are undefined
          default: ;
        endcase
      end
      OP_CMP: begin
        o_cls.sets_flags = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        o_cls.is_imm     = 1'b1;
        o_cls.imm_signed = 1'b1;
        o_cls.writes     = 1'b1;
        o_cls.sets_flags = 1'b1;
      end
      OP_CMPI: begin
        o_cls.is_imm     = 1'b1;
        o_cls.imm_signed = 1'b1;
        o_cls.sets_flags = 1'b1;
      end
      OP_ADDUI: begin
        o_cls.is_imm     = 1'b1;
        o_cls.writes     = 1'b1;
        o_cls.sets_flags = 1'b1;
      end
      OP_MOVI, OP_RSHI: begin
        o_cls.is_imm = 1'b1;
        o_cls.writes = 1'b1;
      end
      OP_MOVIU: begin
        o_cls.swap_ab = 1'b1;
        o_cls.writes  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external ALU/register file:
// IDLE -> READ (operand fetch) -> EXEC (ALU) -> WB (write back, PSR, retire).
// Ports: inst handshake in; ra/rb addr out, data in; alu_a/b/opcode/opext out,
// alu_s/clfzn in; wb_en/addr/data out; psr_clfzn and retired counter out.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [15:0]       inst,
  output logic [REG_AW-1:0] ra_addr,
  output logic [REG_AW-1:0] rb_addr,
  input  logic [15:0]       ra_data,
  input  logic [15:0]       rb_data,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [3:0]        alu_opcode,
  output logic [3:0]        alu_opext,
  input  logic [15:0]       alu_s,
  input  logic [4:0]        alu_clfzn,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [15:0]       wb_data,
  output logic [4:0]        psr_clfzn,
  output logic [CNT_W-1:0]  retired
);

  logic [1:0]       r_state;
  logic [15:0]      r_inst;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [15:0]      r_s;
  logic [4:0]       r_fl;
  logic [4:0]       r_psr;
  logic [CNT_W-1:0] r_ret;

  op_class_t   w_cls;
  logic [15:0] w_a;
  logic [15:0] w_b;

  alu_op_classify u_cls (
    .i_opcode (r_inst[15:12]),
    .i_opext  (r_inst[7:4]),
    .o_cls    (w_cls)
  );

  // MOVIU keeps Rdest in A so the ALU can merge the low byte from B
  always_comb begin
    w_a = ra_data;
    w_b = rb_data;
    if (w_cls.swap_ab) begin
      w_a = rb_data;
      w_b = {8'h00, r_inst[7:0]};
    end else if (w_cls.is_imm) begin
      w_a = imm_ext(r_inst[7:0], w_cls.imm_signed);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_inst  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_fl    <= '0;
      r_psr   <= '0;
      r_ret   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inst_valid) begin
            r_inst  <= inst;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_a     <= w_a;
          r_b     <= w_b;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_s     <= alu_s;
          r_fl    <= alu_clfzn;
          r_state <= ST_WB;
        end
        ST_WB: begin
          if (w_cls.sets_flags) r_psr <= r_fl;
          r_ret   <= r_ret + CNT_W'(1);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign inst_ready = (r_state == ST_IDLE);
  assign ra_addr    = r_inst[REG_AW-1:0];
  assign rb_addr    = r_inst[8 +: REG_AW];
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_inst[15:12];
  assign alu_opext  = r_inst[7:4];
  assign wb_en      = (r_state == ST_WB) && w_cls.writes;
  assign wb_addr    = r_inst[8 +: REG_AW];
  assign wb_data    = r_s;
  assign psr_clfzn  = r_psr;
  assign retired    = r_ret;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: the bench plays register file and ALU,
// driving hand-picked ALU results and checking routing, writeback, PSR, retire.
module tb_alu_issue_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_valid;
  logic          inst_ready;
  logic [15:0]   inst;
  logic [3:0]    ra_addr;
  logic [3:0]    rb_addr;
  logic [15:0]   ra_data;
  logic [15:0]   rb_data;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [3:0]    alu_opcode;
  logic [3:0]    alu_opext;
  logic [15:0]   alu_s;
  logic [4:0]    alu_clfzn;
  logic          wb_en;
  logic [3:0]    wb_addr;
  logic [15:0]   wb_data;
  logic [4:0]    psr_clfzn;
  logic [CW-1:0] retired;

  logic [15:0] rf [16];
  int n_cmp = 0;
  int n_bad = 0;
  int acc;

  always #5 clk = ~clk;

  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];

  alu_issue_ctrl #(.REG_AW(4), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_opext  (alu_opext),
    .alu_s      (alu_s),
    .alu_clfzn  (alu_clfzn),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .psr_clfzn  (psr_clfzn),
    .retired    (retired)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(
    input string       tg,
    input logic [15:0] ins,
    input logic [15:0] ea,
    input logic [15:0] eb,
    input logic [15:0] s,
    input logic [4:0]  fl,
    input logic        ewb,
    input logic [15:0] ed,
    input logic [4:0]  epsr,
    input logic [2:0]  eret
  );
    logic [15:0] v;
    v = ins;
    chk({tg, ".ready_idle"}, 16'(inst_ready), 16'd1);
    inst = ins;
    inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    inst = 16'hFFFF;
    chk({tg, ".ready_busy"}, 16'(inst_ready), 16'd0);
    chk({tg, ".ra_addr"}, 16'(ra_addr), 16'(v[3:0]));
    chk({tg, ".rb_addr"}, 16'(rb_addr), 16'(v[11:8]));
    step();
    chk({tg, ".alu_a"}, alu_a, ea);
    chk({tg, ".alu_b"}, alu_b, eb);
    chk({tg, ".alu_opcode"}, 16'(alu_opcode), 16'(v[15:12]));
    chk({tg, ".alu_opext"}, 16'(alu_opext), 16'(v[7:4]));
    alu_s = s;
    alu_clfzn = fl;
    step();
    chk({tg, ".wb_en"}, 16'(wb_en), 16'(ewb));
    if (ewb) begin
      chk({tg, ".wb_addr"}, 16'(wb_addr), 16'(v[11:8]));
      chk({tg, ".wb_data"}, wb_data, ed);
    end
    step();
    chk({tg, ".wb_en_off"}, 16'(wb_en), 16'd0);
    chk({tg, ".psr"}, 16'(psr_clfzn), 16'(epsr));
    chk({tg, ".retired"}, 16'(retired), 16'(eret));
  endtask

  initial begin
    reset = 1'b1;
    inst_valid = 1'b0;
    inst = 16'h0000;
    alu_s = 16'h0000;
    alu_clfzn = 5'b00000;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    rf[1] = 16'h7FFF;
    rf[2] = 16'h0001;
    rf[3] = 16'h0005;
    rf[4] = 16'h1234;
    rf[5] = 16'h1234;
    rf[6] = 16'h12CD;
    step();
    step();
    chk("rst.ready", 16'(inst_ready), 16'd1);
    chk("rst.wb_en", 16'(wb_en), 16'd0);
    chk("rst.psr", 16'(psr_clfzn), 16'd0);
    chk("rst.retired", 16'(retired), 16'd0);
    chk("rst.alu_a", alu_a, 16'h0000);
    reset = 1'b0;
    step();

    // ADD R2 <= R2 + R1, overflow sets F
    run("add", 16'h0251, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100,
        1'b1, 16'h8000, 5'b00100, 3'd1);
    // SUBI R3, -1
    run("subi", 16'h93FF, 16'hFFFF, 16'h0005, 16'h0006, 5'b10000,
        1'b1, 16'h0006, 5'b10000, 3'd2);
    // CMP R4,R5 equal: flags only
    run("cmp", 16'h3405, 16'h1234, 16'h1234, 16'h0000, 5'b01010,
        1'b0, 16'h0000, 5'b01010, 3'd3);
    // AND must not touch PSR
    run("and", 16'h0211, 16'h7FFF, 16'h0001, 16'h0001, 5'b11111,
        1'b1, 16'h0001, 5'b01010, 3'd4);
    // MOVIU R6, 0xAB
    run("moviu", 16'h76AB, 16'h12CD, 16'h00AB, 16'h12AB, 5'b11111,
        1'b1, 16'h12AB, 5'b01010, 3'd5);
    // ADDI sign-extends 0x80
    run("addi", 16'h5380, 16'hFF80, 16'h0005, 16'hFF85, 5'b00001,
        1'b1, 16'hFF85, 5'b00001, 3'd6);
    // ADDUI zero-extends 0x80
    run("addui", 16'h6380, 16'h0080, 16'h0005, 16'h0085, 5'b00000,
        1'b1, 16'h0085, 5'b00000, 3'd7);
    // undefined opcode: no wb, no PSR, retired wraps 7 -> 0
    run("undef", 16'hF123, 16'h0005, 16'h7FFF, 16'hAAAA, 5'b11111,
        1'b0, 16'h0000, 5'b00000, 3'd0);
    run("nop", 16'h0000, 16'h0000, 16'h0000, 16'h5555, 5'b11111,
        1'b0, 16'h0000, 5'b00000, 3'd1);
    run("cmpi", 16'hB434, 16'h0034, 16'h1234, 16'h1200, 5'b10000,
        1'b0, 16'h0000, 5'b10000, 3'd2);

    // valid held 8 cycles: ready in 1 of every 4
    acc = 0;
    alu_s = 16'h0001;
    alu_clfzn = 5'b11111;
    inst = 16'h8701;
    inst_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (inst_ready) acc++;
      step();
    end
    inst_valid = 1'b0;
    chk("burst.accepts", 16'(acc), 16'd2);
    chk("burst.retired", 16'(retired), 16'd4);
    chk("burst.psr", 16'(psr_clfzn), 16'(5'b10000));

    // reset in EXEC
    inst = 16'h0251;
    inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    step();
    chk("pre_rst.alu_a", alu_a, 16'h7FFF);
    alu_s = 16'h8000;
    alu_clfzn = 5'b00100;
    reset = 1'b1;
    #1;
    chk("rst_exec.alu_a", alu_a, 16'h0000);
    chk("rst_exec.alu_b", alu_b, 16'h0000);
    chk("rst_exec.opext", 16'(alu_opext), 16'd0);
    chk("rst_exec.rb_addr", 16'(rb_addr), 16'd0);
    chk("rst_exec.wb_en", 16'(wb_en), 16'd0);
    chk("rst_exec.psr", 16'(psr_clfzn), 16'd0);
    chk("rst_exec.retired", 16'(retired), 16'd0);
    chk("rst_exec.ready", 16'(inst_ready), 16'd1);
    step();
    chk("rst_hold.wb_en", 16'(wb_en), 16'd0);
    reset = 1'b0;
    #1;
    // first cycle after release accepts
    run("post_rst", 16'h8701, 16'h0001, 16'h0000, 16'h0001, 5'b11111,
        1'b1, 16'h0001, 5'b00000, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
